// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the CPU program loader.
// Pure declarations: no latency, no flow control.
package prog_loader_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;
    localparam int WORD_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_GAP    = 3'd3,
        ST_START  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    function automatic logic [WORD_W-1:0] pack_word(input logic [ADDR_W-1:0]  addr,
                                                    input logic [INSTR_W-1:0] instr);
        return {addr, instr};
    endfunction

endpackage

// File: rtl/loader_pacer.sv
// Loadable down-counter with a zero flag; times SETUP, GAP and START phases.
// Load takes effect next cycle; a loaded value N gives N+1 cycles until zero clears the phase.
// No backpressure: counts every cycle until it reaches zero, then holds.
module loader_pacer #(
    parameter int W = 8
) (
    input  logic         clk1,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk1) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/prog_loader.sv
// Packs a byte stream into {addr, instr} words for the CPU load port, then pulses cpu_rst.
// Accept-to-done latency SETUP_CYC+1; word period SETUP_CYC+GAP_CYC+1. PROG_LOADER_CHECKSUM_EN makes eop a checksum.
// byte_ready is high only in IDLE and on the last GAP cycle; input bytes are held by the source otherwise.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int GAP_CYC   = 2,
    parameter int RST_CYC   = 2
) (
    input  logic               clk1,
    input  logic               rst,
    input  logic               byte_valid,
    input  logic [INSTR_W-1:0] byte_data,
    input  logic               byte_eop,
    output logic               byte_ready,
    output logic [WORD_W-1:0]  load_word,
    output logic               done,
    output logic               cpu_rst,
    output logic               busy,
    output logic               ovf,
    output logic               chk_err
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
    localparam logic [CNT_W-1:0] RST_LD   = CNT_W'(RST_CYC - 1);

    state_t             state, state_next, acc_state;
    logic [ADDR_W-1:0]  addr;
    logic               eop_q, wrapped;
    logic               ready_int, accept;
    logic               pace_load, pace_zero;
    logic [CNT_W-1:0]   pace_val;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] sum;
`endif

    assign accept = byte_valid & ready_int;

    // Where an accepted byte leads: a normal load, a dropped overflow byte, or the checksum verdict.
    always_comb begin
        acc_state = ST_SETUP;
`ifdef PROG_LOADER_CHECKSUM_EN
        if (byte_eop) begin
            acc_state = (byte_data == sum) ? ST_START : ST_FINISH;
        end else if (wrapped) begin
            acc_state = ST_IDLE;
        end
`else
        if (wrapped && !byte_eop) begin
            acc_state = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept) state_next = acc_state;
            ST_SETUP:  if (pace_zero) state_next = ST_STROBE;
            ST_STROBE: begin
                if (eop_q) begin
                    state_next = ST_START;
                end else if (GAP_CYC > 0) begin
                    state_next = ST_GAP;
                end else begin
                    state_next = accept ? acc_state : ST_IDLE;
                end
            end
            ST_GAP:    if (pace_zero) state_next = accept ? acc_state : ST_IDLE;
            ST_START:  if (pace_zero) state_next = ST_FINISH;
            ST_FINISH: state_next = ST_FINISH;
            default:   state_next = ST_IDLE;
        endcase
    end

    // With no gap cycles the strobe cycle doubles as the last gap cycle, keeping a 2-cycle period.
    always_comb begin
        done      = (state == ST_STROBE);
        cpu_rst   = (state == ST_START);
        ready_int = 1'b0;
        case (state)
            ST_IDLE:   ready_int = 1'b1;
            ST_GAP:    ready_int = pace_zero;
            ST_STROBE: ready_int = (GAP_CYC == 0) && !eop_q;
            default:   ready_int = 1'b0;
        endcase
        byte_ready = ready_int & ~rst;
    end

    assign pace_load = (state_next != state);

    always_comb begin
        case (state_next)
            ST_SETUP: pace_val = SETUP_LD;
            ST_GAP:   pace_val = GAP_LD;
            ST_START: pace_val = RST_LD;
            default:  pace_val = '0;
        endcase
    end

    loader_pacer #(.W(CNT_W)) u_pacer (
        .clk1     (clk1),
        .rst      (rst),
        .load     (pace_load),
        .load_val (pace_val),
        .zero     (pace_zero)
    );

    always_ff @(posedge clk1) begin
        if (rst) begin
            load_word <= '0;
            addr      <= '0;
            eop_q     <= 1'b0;
            wrapped   <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (accept && acc_state == ST_SETUP) begin
                load_word <= pack_word(addr, byte_data);
                addr      <= addr + 8'd1;
                eop_q     <= byte_eop;
                if (addr == '1) begin
                    wrapped <= 1'b1;
                end
            end
            if (accept && acc_state == ST_IDLE) begin
                ovf <= 1'b1;
            end
            if (state_next == ST_FINISH) begin
                busy <= 1'b0;
            end else if (accept) begin
                busy <= 1'b1;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    always_ff @(posedge clk1) begin
        if (rst) begin
            sum     <= '0;
            chk_err <= 1'b0;
        end else begin
            if (accept && acc_state == ST_SETUP) begin
                sum <= sum + byte_data;
            end
            if (accept && byte_eop && byte_data != sum) begin
                chk_err <= 1'b1;
            end
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule
